// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings supported by on-chip slaves
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data bus geometry
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LANES     = DATA_W / 8;
    localparam int unsigned WAIT_CNT_W = 4;

    // Slave data-phase state
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_XFER = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slave_state_e;

    // True for NONSEQ/SEQ, i.e. an HTRANS that requests a transfer
    function automatic logic trans_active(input logic [1:0] trans);
        return !((trans == HTRANS_IDLE) || (trans == HTRANS_BUSY));
    endfunction

endpackage

// File: rtl/ahb_byte_lane_gen.sv
// Byte-lane strobe and legality decode for a 32-bit little-endian AHB slave.
module ahb_byte_lane_gen
    import ahb_pkg::*;
(
    input  logic [2:0]       hsize,
    input  logic [1:0]       addr_lo,
    output logic [LANES-1:0] lanes,
    output logic             illegal
);

    // Lane n carries bits [8n+7:8n]; sizes wider than a word or misaligned are illegal
    always_comb begin
        lanes   = '0;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                lanes = LANES'(1) << addr_lo;
            end
            HSIZE_HALF: begin
                lanes   = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                lanes   = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: begin
                lanes   = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite on-chip SRAM slave: byte/half/word access, programmable wait states,
// two-cycle ERROR response for illegal size/alignment.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W  = 15,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned WORD_W    = MEM_ADDR_W - 2;
    localparam int unsigned MEM_WORDS = 1 << WORD_W;

    slave_state_e              state;
    logic [WAIT_CNT_W-1:0]     wait_cnt;
    logic [MEM_ADDR_W-1:0]     addr_q;
    logic                      write_q;
    logic [LANES-1:0]          lanes_q;
    logic                      ready_q;
    logic                      resp_q;
    logic [DATA_W-1:0]         rdata_hold;

    logic [LANES-1:0]          lanes_c;
    logic                      illegal_c;
    logic                      accept_c;
    logic [WORD_W-1:0]         word_idx_c;
    logic [DATA_W-1:0]         mem_word_c;

    logic [DATA_W-1:0]         mem [MEM_WORDS];

    // Address bits above the window alias and are deliberately ignored
    logic unused_haddr;
    assign unused_haddr = ^HADDR[31:MEM_ADDR_W];

    // Size/alignment decode of the address phase
    ahb_byte_lane_gen u_lane_gen (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .lanes   (lanes_c),
        .illegal (illegal_c)
    );

    assign accept_c   = HSEL & HREADY & trans_active(HTRANS);
    assign word_idx_c = addr_q[MEM_ADDR_W-1:2];
    assign mem_word_c = mem[word_idx_c];

    // Data-phase FSM with registered HREADYOUT/HRESP and address-phase capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            lanes_q  <= '0;
            ready_q  <= 1'b1;
            resp_q   <= HRESP_OKAY;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == WAIT_CNT_W'(WAIT_STATES)) begin
                        state    <= S_XFER;
                        wait_cnt <= '0;
                        ready_q  <= 1'b1;
                        resp_q   <= HRESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                S_ERR1: begin
                    state   <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= HRESP_ERROR;
                end
                default: begin
                    // IDLE, XFER and ERR2 all drive HREADYOUT=1 and may take a new address phase
                    if (accept_c) begin
                        addr_q  <= HADDR[MEM_ADDR_W-1:0];
                        write_q <= HWRITE;
                        lanes_q <= lanes_c;
                        if (illegal_c) begin
                            state   <= S_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_CNT_W'(1);
                            ready_q  <= 1'b0;
                            resp_q   <= HRESP_OKAY;
                        end else begin
                            state   <= S_XFER;
                            ready_q <= 1'b1;
                            resp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Byte-lane write commits at the edge that closes XFER
    always_ff @(posedge HCLK) begin
        if ((state == S_XFER) && write_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (lanes_q[i]) begin
                    mem[word_idx_c][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read data is held after a read completes so HRDATA does not glitch to zero
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata_hold <= '0;
        end else if ((state == S_XFER) && !write_q) begin
            rdata_hold <= mem_word_c;
        end
    end

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = ((state == S_XFER) && !write_q) ? mem_word_c : rdata_hold;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one 3-wait-state instance.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        ready0, resp0, ready3, resp3;
    logic [31:0] rdata0, rdata3;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_ADDR_W(15), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ready0),
        .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_sram_slave #(.MEM_ADDR_W(15), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ready3),
        .HREADYOUT(ready3), .HRESP(resp3), .HRDATA(rdata3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic s3, input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel0  = !s3;
        hsel3  = s3;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        idle_bus();
        haddr  = '0;
        hsize  = 3'b010;
        hwdata = '0;
        repeat (2) step();
        checks++; if (ready0 !== 1'b1) begin fails++; $display("FAIL reset_ready0 got %b want 1", ready0); end
        checks++; if (resp0 !== 1'b0) begin fails++; $display("FAIL reset_resp0 got %b want 0", resp0); end
        checks++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
        checks++; if (ready3 !== 1'b1) begin fails++; $display("FAIL reset_ready3 got %b want 1", ready3); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word_rw();
        addr_ph(1'b0, 32'h1000_0010, 1'b1, 3'b010);
        step();
        checks++; if (ready0 !== 1'b1) begin fails++; $display("FAIL wr_dphase_ready got %b want 1", ready0); end
        hwdata = 32'hDEAD_BEEF;
        addr_ph(1'b0, 32'h1000_0010, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_b2b_data got %h want deadbeef", rdata0); end
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin fails++; $display("FAIL rd_dphase_okay got %b/%b want 1/0", ready0, resp0); end
        addr_ph(1'b0, 32'h2000_0010, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL alias_read got %h want deadbeef", rdata0); end
        idle_bus();
        step();
    endtask

    task automatic test_byte_lanes();
        addr_ph(1'b0, 32'h1000_0020, 1'b1, 3'b010);
        step();
        hwdata = 32'h1122_3344;
        addr_ph(1'b0, 32'h1000_0022, 1'b1, 3'b000);
        step();
        hwdata = 32'hFFAA_FFFF;
        addr_ph(1'b0, 32'h1000_0020, 1'b1, 3'b001);
        step();
        hwdata = 32'hEEEE_5566;
        addr_ph(1'b0, 32'h1000_0020, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'h11AA_5566) begin fails++; $display("FAIL lanes_word got %h want 11aa5566", rdata0); end
        addr_ph(1'b0, 32'h1000_0023, 1'b0, 3'b000);
        step();
        checks++; if (rdata0 !== 32'h11AA_5566) begin fails++; $display("FAIL lanes_byte_read got %h want 11aa5566", rdata0); end
        idle_bus();
        step();
        checks++; if (rdata0 !== 32'h11AA_5566) begin fails++; $display("FAIL rdata_hold got %h want 11aa5566", rdata0); end
    endtask

    task automatic test_reset_async();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL async_rst_rdata got %h want 0", rdata0); end
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin fails++; $display("FAIL async_rst_resp got %b/%b want 1/0", ready0, resp0); end
        step();
        rst_n = 1'b1;
        step();
        addr_ph(1'b0, 32'h1000_0020, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'h11AA_5566) begin fails++; $display("FAIL mem_survives_rst got %h want 11aa5566", rdata0); end
        idle_bus();
        step();
    endtask

    task automatic test_wait_states();
        addr_ph(1'b1, 32'h1000_0040, 1'b1, 3'b010);
        step();
        idle_bus();
        hwdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ready3 !== 1'b0 || resp3 !== 1'b0) begin fails++; $display("FAIL ws_wr_wait%0d got %b/%b want 0/0", i, ready3, resp3); end
            step();
        end
        checks++; if (ready3 !== 1'b1 || resp3 !== 1'b0) begin fails++; $display("FAIL ws_wr_xfer got %b/%b want 1/0", ready3, resp3); end
        step();
        addr_ph(1'b1, 32'h1000_0040, 1'b0, 3'b010);
        step();
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ready3 !== 1'b0 || resp3 !== 1'b0) begin fails++; $display("FAIL ws_rd_wait%0d got %b/%b want 0/0", i, ready3, resp3); end
            step();
        end
        checks++; if (ready3 !== 1'b1 || resp3 !== 1'b0) begin fails++; $display("FAIL ws_rd_xfer got %b/%b want 1/0", ready3, resp3); end
        checks++; if (rdata3 !== 32'hCAFE_F00D) begin fails++; $display("FAIL ws_rd_data got %h want cafef00d", rdata3); end
        step();
    endtask

    task automatic test_error();
        addr_ph(1'b0, 32'h1000_0000, 1'b1, 3'b010);
        step();
        hwdata = 32'h0102_0304;
        addr_ph(1'b0, 32'h1000_0000, 1'b1, 3'b011);
        step();
        hwdata = 32'hFFFF_FFFF;
        idle_bus();
        checks++; if (ready0 !== 1'b0 || resp0 !== 1'b1) begin fails++; $display("FAIL err_size_c1 got %b/%b want 0/1", ready0, resp0); end
        step();
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b1) begin fails++; $display("FAIL err_size_c2 got %b/%b want 1/1", ready0, resp0); end
        addr_ph(1'b0, 32'h1000_0000, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'h0102_0304) begin fails++; $display("FAIL err_size_mem got %h want 01020304", rdata0); end
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin fails++; $display("FAIL err_pipe_okay got %b/%b want 1/0", ready0, resp0); end
        addr_ph(1'b0, 32'h1000_0001, 1'b1, 3'b001);
        step();
        hwdata = 32'hFFFF_FFFF;
        idle_bus();
        checks++; if (ready0 !== 1'b0 || resp0 !== 1'b1) begin fails++; $display("FAIL err_mis_c1 got %b/%b want 0/1", ready0, resp0); end
        step();
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b1) begin fails++; $display("FAIL err_mis_c2 got %b/%b want 1/1", ready0, resp0); end
        step();
        addr_ph(1'b0, 32'h1000_0000, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'h0102_0304) begin fails++; $display("FAIL err_mis_mem got %h want 01020304", rdata0); end
        addr_ph(1'b1, 32'h1000_0003, 1'b0, 3'b010);
        step();
        idle_bus();
        checks++; if (ready3 !== 1'b0 || resp3 !== 1'b1) begin fails++; $display("FAIL err_ws_c1 got %b/%b want 0/1", ready3, resp3); end
        step();
        checks++; if (ready3 !== 1'b1 || resp3 !== 1'b1) begin fails++; $display("FAIL err_ws_c2 got %b/%b want 1/1", ready3, resp3); end
        step();
        checks++; if (ready3 !== 1'b1 || resp3 !== 1'b0) begin fails++; $display("FAIL err_ws_done got %b/%b want 1/0", ready3, resp3); end
    endtask

    task automatic test_non_transfers();
        hsel0  = 1'b1;
        haddr  = 32'h1000_0000;
        hwrite = 1'b1;
        hsize  = 3'b010;
        htrans = 2'b00;
        step();
        hwdata = 32'hFFFF_FFFF;
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin fails++; $display("FAIL nt_idle got %b/%b want 1/0", ready0, resp0); end
        htrans = 2'b01;
        step();
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin fails++; $display("FAIL nt_busy got %b/%b want 1/0", ready0, resp0); end
        hsel0  = 1'b0;
        htrans = 2'b10;
        step();
        checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin fails++; $display("FAIL nt_unsel got %b/%b want 1/0", ready0, resp0); end
        idle_bus();
        step();
        addr_ph(1'b0, 32'h1000_0000, 1'b0, 3'b010);
        step();
        checks++; if (rdata0 !== 32'h0102_0304) begin fails++; $display("FAIL nt_mem got %h want 01020304", rdata0); end
        idle_bus();
        step();
    endtask

    task automatic test_reset_in_wait();
        int n;
        addr_ph(1'b1, 32'h1000_0040, 1'b1, 3'b010);
        step();
        idle_bus();
        hwdata = 32'h1234_5678;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ready3 !== 1'b1 || resp3 !== 1'b0) begin fails++; $display("FAIL rst_wait_out got %b/%b want 1/0", ready3, resp3); end
        step();
        rst_n = 1'b1;
        step();
        addr_ph(1'b1, 32'h1000_0040, 1'b0, 3'b010);
        step();
        idle_bus();
        n = 0;
        while (ready3 !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++; if (n >= 10) begin fails++; $display("FAIL rst_wait_timeout got %0d cycles want <10", n); end
        checks++; if (rdata3 !== 32'hCAFE_F00D) begin fails++; $display("FAIL rst_wait_discard got %h want cafef00d", rdata3); end
        step();
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_reset_async();
        test_wait_states();
        test_error();
        test_non_transfers();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
